// File: rtl/weight_bit_serializer.sv
`timescale 1ns/1ps
// weight_bit_serializer
//   Feeder for the bit-serial neuron multiplier. Buffers {neuron, weight}
//   operand pairs in a small FIFO and streams each sign-magnitude weight one
//   bit per clock: magnitude MSB..LSB first, then the sign bit last. The
//   neuron word is held on neuron_out for the whole word window.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   weight_in     weight word (sign-magnitude Q5.10)
//   neuron_in     neuron word paired with weight_in
//   in_valid      pair presented
//   in_ready      FIFO can accept a pair (combinational from registered count)
//   weight_bit    serial weight bit to the multiplier
//   mult_enable   multiplier enable, high DATA_WIDTH cycles per word
//   neuron_out    neuron word held for the active word
//   product_valid one-cycle pulse when the multiplier output holds the product
//   busy          serializer shifting or FIFO non-empty
//   fifo_count    occupied FIFO entries
//   dbg_state     current FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake: a pair transfers on a rising clk edge where in_valid && in_ready.
// in_valid may be raised or dropped at any time; the data must be stable
// while in_valid is high and in_ready is low. A full FIFO refuses the push
// even if a pop happens on the same edge.
module weight_bit_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 2,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] weight_in,
  input  logic [DATA_WIDTH-1:0] neuron_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  weight_bit,
  output logic                  mult_enable,
  output logic [DATA_WIDTH-1:0] neuron_out,
  output logic                  product_valid,
  output logic                  busy,
  output logic [CNT_W-1:0]      fifo_count,
  output logic [0:0]            dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BC_W  = $clog2(DATA_WIDTH);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [DATA_WIDTH-1:0] weight_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] neuron_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_next;

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [BC_W-1:0]       bit_cnt;
  // Bits still to be sent for the current word, next bit in the MSB.
  logic [DATA_WIDTH-2:0] shreg;

  logic push;
  logic pop;
  logic fifo_nonempty;
  logic word_end;
  logic [DATA_WIDTH-1:0] pop_weight;
  logic [DATA_WIDTH-1:0] pop_neuron;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready      = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push          = in_valid && in_ready;
  assign fifo_nonempty = (fifo_count != '0);
  assign word_end      = (state == SHIFT) && (bit_cnt == BIT_LAST);
  // Popping on the last bit of a word keeps mult_enable contiguous.
  assign pop           = fifo_nonempty && ((state == IDLE) || word_end);
  assign pop_weight    = weight_mem[rd_ptr];
  assign pop_neuron    = neuron_mem[rd_ptr];
  assign dbg_state     = state;

  always_comb begin
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + 1'b1;
      2'b01:   count_next = fifo_count - 1'b1;
      default: count_next = fifo_count;
    endcase
  end

  always_comb begin
    state_next = state;
    if (pop)           state_next = SHIFT;
    else if (word_end) state_next = IDLE;
  end

  // Storage needs no reset: entries are only read when counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      weight_mem[wr_ptr] <= weight_in;
      neuron_mem[wr_ptr] <= neuron_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= count_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      weight_bit    <= 1'b0;
      mult_enable   <= 1'b0;
      neuron_out    <= '0;
      product_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= state_next;
      // The multiplier captures the sign bit on the edge that ends the word,
      // so its product is valid during the following cycle.
      product_valid <= word_end;
      busy          <= (state_next == SHIFT) || (count_next != '0);
      if (pop) begin
        // Magnitude MSB goes out first; the remaining magnitude bits are
        // followed by the sign bit.
        weight_bit  <= pop_weight[DATA_WIDTH-2];
        shreg       <= {pop_weight[DATA_WIDTH-3:0], pop_weight[DATA_WIDTH-1]};
        neuron_out  <= pop_neuron;
        bit_cnt     <= '0;
        mult_enable <= 1'b1;
      end else if (word_end) begin
        weight_bit  <= 1'b0;
        mult_enable <= 1'b0;
        bit_cnt     <= '0;
      end else if (state == SHIFT) begin
        weight_bit  <= shreg[DATA_WIDTH-2];
        shreg       <= {shreg[DATA_WIDTH-3:0], 1'b0};
        bit_cnt     <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_weight_bit_serializer.sv
`timescale 1ns/1ps
module tb_weight_bit_serializer;

  localparam int DW    = 16;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] weight_in;
  logic [DW-1:0] neuron_in;
  logic          in_valid;
  logic          in_ready;
  logic          weight_bit;
  logic          mult_enable;
  logic [DW-1:0] neuron_out;
  logic          product_valid;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic [0:0]    dbg_state;

  always #5 clk = ~clk;

  weight_bit_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .weight_in(weight_in), .neuron_in(neuron_in),
    .in_valid(in_valid), .in_ready(in_ready), .weight_bit(weight_bit),
    .mult_enable(mult_enable), .neuron_out(neuron_out),
    .product_valid(product_valid), .busy(busy), .fifo_count(fifo_count),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [15:0] weight;
    logic [15:0] neuron;
    logic [15:0] product;
  } vec_t;

  vec_t vecs[5];

  // {neuron, weight, product}
  logic [47:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference sign-magnitude Q5.10 product (operands kept small, no saturation).
  function automatic logic [15:0] ref_product(input logic [15:0] w, input logic [15:0] n);
    logic [31:0] m;
    m = 32'(w[14:0]) * 32'(n[14:0]);
    return {w[15] ^ n[15], m[24:10]};
  endfunction

  // ---------------- monitor / behavioural bit-serial multiplier ----------------
  int          idx = 0;
  logic        pending = 1'b0;
  logic [31:0] acc;
  logic [15:0] w_rec, n_first;
  logic [15:0] done_prod, done_w, done_n0, done_n15;
  int          cyc = 0;
  int          en_run = 0;
  int          last_run = 0;
  int          last_pv_cyc = 0;
  int          pv_gaps[$];

  always @(negedge clk) begin
    logic [47:0] e;
    cyc++;
    if (reset) begin
      idx = 0; pending = 1'b0; acc = '0; en_run = 0;
    end else begin
      if (pending) begin
        pending = 1'b0;
        check("pv_timing", product_valid, 1);
        if (exp_q.size() == 0) fail_now("sb_unexpected_word");
        else begin
          e = exp_q.pop_front();
          check("weight_stream", done_w, e[31:16]);
          check("neuron_first", done_n0, e[47:32]);
          check("neuron_last", done_n15, e[47:32]);
          check("product", done_prod, e[15:0]);
        end
      end else if (product_valid) begin
        fail_now("pv_unexpected");
      end
      if (product_valid) begin
        pv_gaps.push_back(cyc - last_pv_cyc);
        last_pv_cyc = cyc;
      end
      if (mult_enable) begin
        en_run++;
        if (idx == 0) begin
          n_first = neuron_out;
          acc = '0;
        end
        if (idx < 15) begin
          w_rec[14-idx] = weight_bit;
          acc = (acc << 1) + (weight_bit ? 32'(n_first[14:0]) : 32'd0);
          idx++;
        end else begin
          w_rec[15] = weight_bit;
          done_prod = {weight_bit ^ n_first[15], acc[24:10]};
          done_w    = w_rec;
          done_n0   = n_first;
          done_n15  = neuron_out;
          pending   = 1'b1;
          idx       = 0;
        end
      end else begin
        if (en_run != 0) begin
          last_run = en_run;
          en_run = 0;
        end
        if (idx != 0) begin
          fail_now("enable_gap");
          idx = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge; returns just after the negedge following
  // the accepting edge, with in_valid still high.
  task automatic push_pair(input logic [15:0] w, input logic [15:0] n, output int stall);
    stall = 0;
    weight_in = w;
    neuron_in = n;
    in_valid  = 1'b1;
    exp_q.push_back({n, w, ref_product(w, n)});
    while (!in_ready && stall < 100) begin
      @(negedge clk);
      stall++;
    end
    if (!in_ready) begin
      fail_now("push_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy || mult_enable) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stall;
    logic [15:0] w, n;
    logic exp_bit;

    vecs[0] = '{16'h0C00, 16'h0800, 16'h1800};
    vecs[1] = '{16'h8C00, 16'h0800, 16'h9800};
    vecs[2] = '{16'h0400, 16'h0400, 16'h0400};
    vecs[3] = '{16'h0800, 16'h0400, 16'h0800};
    vecs[4] = '{16'h8400, 16'h0C00, 16'h8C00};

    reset = 1'b1; in_valid = 1'b0; weight_in = '0; neuron_in = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_weight_bit", weight_bit, 0);
    check("rst_mult_enable", mult_enable, 0);
    check("rst_neuron_out", neuron_out, 0);
    check("rst_product_valid", product_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_mult_enable", mult_enable, 0);

    // Table: each vector as a single word with full latency and bit checks.
    for (int i = 0; i < 5; i++) begin
      check("table_ref", ref_product(vecs[i].weight, vecs[i].neuron), vecs[i].product);
      push_pair(vecs[i].weight, vecs[i].neuron, stall);
      in_valid = 1'b0;
      check("lat_idle_e0", mult_enable, 0);
      w = vecs[i].weight;
      for (int k = 1; k <= 17; k++) begin
        @(negedge clk);
        if (k <= 16) begin
          exp_bit = (k <= 15) ? w[15-k] : w[15];
          check("lat_enable", mult_enable, 1);
          check("lat_bit", weight_bit, exp_bit);
          if (k == 8) check("shift_state", dbg_state, 1);
        end else begin
          check("lat_enable_off", mult_enable, 0);
          check("lat_bit_off", weight_bit, 0);
          check("lat_pv", product_valid, 1);
        end
      end
      wait_drain();
      check("single_run_len", last_run, 16);
      check("neuron_held_idle", neuron_out, vecs[i].neuron);
    end

    // Back-to-back: last three table entries on consecutive cycles.
    pv_gaps.delete();
    for (int i = 2; i < 5; i++) push_pair(vecs[i].weight, vecs[i].neuron, stall);
    in_valid = 1'b0;
    wait_drain();
    check("b2b_run_len", last_run, 48);
    check("b2b_pv_count", pv_gaps.size(), 3);
    if (pv_gaps.size() == 3) begin
      check("b2b_pv_gap1", pv_gaps[1], 16);
      check("b2b_pv_gap2", pv_gaps[2], 16);
    end

    // Random back-to-back words.
    for (int i = 0; i < 4; i++) begin
      w = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 16'h07FF))};
      n = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 16'h1FFF))};
      push_pair(w, n, stall);
    end
    in_valid = 1'b0;
    wait_drain();
    check("rand_run_len", last_run, 64);

    // FIFO full: in_valid held across four distinct pairs.
    push_pair(16'h0400, 16'h0400, stall);
    push_pair(16'h0800, 16'h0800, stall);
    push_pair(16'h8C00, 16'h0400, stall);
    check("full_count", fifo_count, 2);
    check("full_in_ready", in_ready, 0);
    check("full_busy", busy, 1);
    push_pair(16'h0200, 16'h1000, stall);
    in_valid = 1'b0;
    check("full_stall_cycles", stall, 15);
    wait_drain();
    check("full_run_len", last_run, 64);

    // Reset mid-word with one pair queued.
    push_pair(16'h0CFF, 16'h0400, stall);
    push_pair(16'h0400, 16'h0400, stall);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_pre_bit_k7", weight_bit, 1);
    check("mid_pre_count", fifo_count, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_enable", mult_enable, 0);
    check("mid_rst_bit", weight_bit, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_pv", product_valid, 0);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_idle_enable", mult_enable, 0);
    push_pair(16'h0400, 16'h0400, stall);
    in_valid = 1'b0;
    wait_drain();
    check("post_rst_run_len", last_run, 16);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    fail_now("watchdog");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/weight_bit_serializer.md
Name: weight_bit_serializer

Overview:
- Feeder for the bit-serial neuron multiplier. Accepts {neuron, weight} operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Streams each 16-bit sign-magnitude Q5.10 weight one bit per clock in the order the multiplier consumes it:
  - magnitude bits 14 down to 0, MSB first;
  - then sign bit 15.
- Holds the matching neuron word stable on the multiplier input for the whole 16-cycle window.
- Flags the cycle in which the multiplier's product output is valid.

Parameters:
- DATA_WIDTH, 16, neuron/weight word width (sign-magnitude, 1 sign + 5 integer + 10 fraction bits).
- FIFO_DEPTH, 2, operand-pair buffer entries (power of two, ≥1).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high reset.
- weight_in, input, 16, weight word (sign-magnitude Q5.10).
- neuron_in, input, 16, neuron word paired with weight_in.
- in_valid, input, 1, pair presented.
- in_ready, output, 1, FIFO can accept a pair.
- weight_bit, output, 1, serial weight bit to the multiplier.
- mult_enable, output, 1, multiplier enable; high exactly 16 cycles per word.
- neuron_out, output, 16, neuron word held for the active word.
- product_valid, output, 1, one-cycle pulse when the multiplier output holds the product of the word just streamed.
- busy, output, 1, serializer in SHIFT or FIFO non-empty.
- fifo_count, output, clog2(FIFO_DEPTH)+1, occupied entries.

Behaviour:
- Reset: clk and reset are a single clock domain; reset is asynchronous and active-high. Reset is the only way to resynchronise with the multiplier, so the multiplier's reset must be released on the same edge as this block's reset.
  - Values while reset is high and after release: in_ready=1, weight_bit=0, mult_enable=0, neuron_out=0, product_valid=0, busy=0, fifo_count=0.
  - Internal state after reset: FIFO pointers 0, state IDLE, bit_cnt 0.
- Handshake:
  - A pair is accepted on a rising edge with in_valid && in_ready.
  - in_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - A push and a pop on the same edge leave the count unchanged. Full blocks the push even if a pop occurs that edge, so in_ready reasserts the cycle after the pop.
- State machine:
  - IDLE: mult_enable=0, weight_bit=0. If FIFO non-empty: pop into the shift register and neuron_out, set bit_cnt=0, go to SHIFT.
  - SHIFT, with bit_cnt = k in 0..15:
    - k in 0..14: weight_bit = w[14-k].
    - k = 15: weight_bit = w[15] (sign).
    - mult_enable = 1 throughout.
  - At the edge ending k=15:
    - If FIFO non-empty: pop the next pair and stay in SHIFT with k=0, giving zero bubble and contiguous mult_enable.
    - Else: go to IDLE.
- Outputs: all are registered except in_ready.
- Latency:
  - Pair accepted at edge E0 into an empty, idle block: first bit presented after E1.
  - mult_enable is high in the 16 cycles following E1..E16.
  - The multiplier captures the final (sign) bit at E17 and updates its output at E17.
  - product_valid is high for exactly the cycle following E17.
  - A pair accepted while SHIFT is active starts on the edge ending the current word's k=15.
- neuron_out changes only on pop and is otherwise held, including in IDLE (last value retained).
- Back-to-back words: product_valid pulses every 16 cycles. It may coincide with k=0 of the next word.
- Arithmetic: none. Words are passed bit-exact and no saturation is applied here; saturation is the multiplier's job.
- Reset asserted mid-word: outputs go to reset values immediately, with no pending product_valid and all FIFO contents discarded.

Test Plan:
- Single word: weight_in=0x0C00 (3.0), neuron_in=0x0800 (2.0), one-cycle valid.
  - weight_bit sequence over 16 cycles = 0,0,0,1,1,0,0,0,0,0,0,0,0,0,0,0.
  - mult_enable high 16 cycles; product_valid at cycle 17 after accept.
  - Multiplier out=0x1800 (6.0).
- Negative weight: weight_in=0x8C00, neuron_in=0x0800.
  - Same magnitude bits; 16th bit = 1.
  - Multiplier out=0x9800 at the product_valid cycle.
- Back-to-back: push 3 pairs (0x0400×0x0400, 0x0800×0x0400, 0x8400×0x0C00) on consecutive cycles.
  - mult_enable high 48 contiguous cycles.
  - product_valid pulses 16 cycles apart.
  - Products 0x0400, 0x0800, 0x8C00.
- FIFO full: hold in_valid with 4 distinct pairs.
  - in_ready drops when fifo_count=2 (one word in SHIFT).
  - Reasserts the cycle after the next pop.
  - All 4 words are streamed in order with none lost or duplicated.
- Reset mid-word: assert reset at k=7 of a word with 1 pair queued.
  - mult_enable and weight_bit go to 0 without waiting for a clock edge.
  - fifo_count=0, no product_valid.
  - After release, a new pair 0x0400×0x0400 produces 0x0400.
